// File: rtl/sif_fp_pkg.sv
// sif_fp_pkg: shared definitions for the iterative floating-point divider.
//   state_e    - divider control states
//   FLG_*      - bit positions inside the 5-bit exception flag vector
//   canon_nan  - canonical quiet NaN pattern for a given EXP_W/MAN_W
package sif_fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM_RND,
        ST_OUT
    } state_e;

    localparam int FLG_W  = 5;
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Sign 0, exponent all ones, only the mantissa MSB set. Returned in a
    // 64-bit container; callers keep the low 1+EXP_W+MAN_W bits.
    function automatic logic [63:0] canon_nan(input int unsigned exp_w,
                                              input int unsigned man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/sif_div_fp_iter_if.sv
// sif_div_fp_iter_if: operand/result streams of the floating-point divider.
//   A_*     - dividend stream (vld/dat in, rdy out at the divider)
//   B_*     - divisor stream
//   P_*     - quotient stream plus P_flags {NV, DZ, OF, UF, NX}
//   busy    - divider not idle
// master: stream producer/consumer side; slave: the divider.
interface sif_div_fp_iter_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         A_vld;
    logic [W-1:0] A_dat;
    logic         A_rdy;
    logic         B_vld;
    logic [W-1:0] B_dat;
    logic         B_rdy;
    logic         P_vld;
    logic [W-1:0] P_dat;
    logic         P_rdy;
    logic [4:0]   P_flags;
    logic         busy;

    modport master (
        output A_vld, A_dat, B_vld, B_dat, P_rdy,
        input  A_rdy, B_rdy, P_vld, P_dat, P_flags, busy
    );

    modport slave (
        input  A_vld, A_dat, B_vld, B_dat, P_rdy,
        output A_rdy, B_rdy, P_vld, P_dat, P_flags, busy
    );
endinterface

// File: rtl/sif_fp_classify.sv
// sif_fp_classify: combinational decode of one IEEE-style operand.
//   dat     - packed operand {sign, exponent, fraction}
//   is_zero - zero or subnormal (subnormals are flushed to zero)
//   is_inf  - exponent all ones, fraction zero
//   is_nan  - exponent all ones, fraction nonzero
//   sign    - sign bit
//   expo    - biased exponent field
//   sig     - significand with hidden bit (0 for flushed operands)
module sif_fp_classify #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] dat,
    output logic                 is_zero,
    output logic                 is_inf,
    output logic                 is_nan,
    output logic                 sign,
    output logic [EXP_W-1:0]     expo,
    output logic [MAN_W:0]       sig
);
    logic [MAN_W-1:0] frac;
    logic             exp_max;
    logic             exp_min;

    always_comb begin
        frac    = dat[MAN_W-1:0];
        expo    = dat[MAN_W +: EXP_W];
        sign    = dat[EXP_W+MAN_W];
        exp_max = &expo;
        exp_min = ~|expo;
        is_zero = exp_min;
        is_inf  = exp_max & ~|frac;
        is_nan  = exp_max & |frac;
        sig     = exp_min ? '0 : {1'b1, frac};
    end
endmodule

// File: rtl/sif_div_fp_iter.sv
// sif_div_fp_iter: iterative floating-point divider (default FP16).
//   clk, rst_n - clock, asynchronous active-low reset
//   io         - slave side of sif_div_fp_iter_if: A (dividend), B (divisor)
//                and P (quotient + flags) valid/ready streams, busy
// Both operands are accepted together; special operands finish in one
// cycle, normal ones run a radix-2 restoring division of MAN_W+3 quotient
// bits followed by one normalise/round-to-nearest-even cycle.
module sif_div_fp_iter
    import sif_fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    sif_div_fp_iter_if.slave io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int QW = MAN_W + 3;
    localparam int RW = MAN_W + 2;
    localparam int CW = $clog2(MAN_W + 4);

    localparam logic [CW-1:0]        CNT_INIT = CW'(MAN_W + 2);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic signed [EW-1:0] BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_E   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E    = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E   = '0;
    localparam logic [63:0]          NAN64    = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN     = NAN64[W-1:0];

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [QW-1:0]         quo_q, quo_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [MAN_W:0]        mb_q, mb_d;
    logic signed [EW-1:0]  e_q, e_d;
    logic                  s_q, s_d;
    logic [W-1:0]          p_dat_q, p_dat_d;
    logic [FLG_W-1:0]      p_flags_q, p_flags_d;

    logic                  a_zero, a_inf, a_nan, a_sign;
    logic                  b_zero, b_inf, b_nan, b_sign;
    logic [EXP_W-1:0]      a_exp, b_exp;
    logic [MAN_W:0]        a_sig, b_sig;

    logic                  accept;
    logic                  res_s;
    logic                  rem_ge;
    logic [RW-1:0]         rem_sub;
    logic [MAN_W-1:0]      frac;
    logic                  guard, sticky, round_up;
    logic [MAN_W:0]        frac_inc;
    logic signed [EW-1:0]  e_n, e_r;

    sif_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .dat(io.A_dat), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan),
        .sign(a_sign), .expo(a_exp), .sig(a_sig)
    );

    sif_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .dat(io.B_dat), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan),
        .sign(b_sign), .expo(b_exp), .sig(b_sig)
    );

    assign accept     = (state_q == ST_IDLE) & io.A_vld & io.B_vld;
    assign io.A_rdy   = accept;
    assign io.B_rdy   = accept;
    assign io.P_vld   = (state_q == ST_OUT);
    assign io.busy    = (state_q != ST_IDLE);
    assign io.P_dat   = p_dat_q;
    assign io.P_flags = p_flags_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        mb_d      = mb_q;
        e_d       = e_q;
        s_d       = s_q;
        p_dat_d   = p_dat_q;
        p_flags_d = p_flags_q;

        res_s = a_sign ^ b_sign;

        // One restoring step: subtract divisor when it fits, shift remainder.
        rem_ge  = rem_q >= {1'b0, mb_q};
        rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

        // Quotient lies in (0.5, 2); the MSB decides the normalising shift.
        // The hidden bit is always 1 here, so only the fraction is rounded.
        if (quo_q[QW-1]) begin
            frac   = quo_q[QW-2:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (|rem_q);
            e_n    = e_q;
        end else begin
            frac   = quo_q[QW-3:1];
            guard  = quo_q[0];
            sticky = |rem_q;
            e_n    = e_q - ONE_E;
        end
        round_up = guard & (sticky | frac[0]);
        frac_inc = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        // Fraction carry-out means the significand rounded up to 2.0:
        // fraction bits are already zero, only the exponent moves.
        e_r      = frac_inc[MAN_W] ? (e_n + ONE_E) : e_n;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_OUT;
                    p_flags_d = '0;
                    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                        p_dat_d           = QNAN;
                        p_flags_d[FLG_NV] = ~(a_nan | b_nan);
                    end else if (b_zero & ~a_inf) begin
                        p_dat_d           = {res_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        p_flags_d[FLG_DZ] = 1'b1;
                    end else if (a_inf) begin
                        p_dat_d = {res_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (a_zero | b_inf) begin
                        p_dat_d = {res_s, {(W-1){1'b0}}};
                    end else begin
                        state_d = ST_DIV;
                        rem_d   = {1'b0, a_sig};
                        mb_d    = b_sig;
                        quo_d   = '0;
                        cnt_d   = CNT_INIT;
                        s_d     = res_s;
                        e_d     = $signed(EW'(a_exp)) - $signed(EW'(b_exp)) + BIAS_E;
                    end
                end
            end
            ST_DIV: begin
                quo_d = {quo_q[QW-2:0], rem_ge};
                rem_d = rem_sub << 1;
                if (cnt_q == '0) begin
                    state_d = ST_NORM_RND;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_NORM_RND: begin
                state_d   = ST_OUT;
                p_flags_d = '0;
                if (e_r >= EMAX_E) begin
                    p_dat_d           = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    p_flags_d[FLG_OF] = 1'b1;
                    p_flags_d[FLG_NX] = 1'b1;
                end else if (e_r <= ZERO_E) begin
                    p_dat_d           = {s_q, {(W-1){1'b0}}};
                    p_flags_d[FLG_UF] = 1'b1;
                    p_flags_d[FLG_NX] = 1'b1;
                end else begin
                    p_dat_d           = {s_q, e_r[EXP_W-1:0], frac_inc[MAN_W-1:0]};
                    p_flags_d[FLG_NX] = guard | sticky;
                end
            end
            ST_OUT: begin
                if (io.P_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            mb_q      <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
            p_dat_q   <= '0;
            p_flags_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            mb_q      <= mb_d;
            e_q       <= e_d;
            s_q       <= s_d;
            p_dat_q   <= p_dat_d;
            p_flags_q <= p_flags_d;
        end
    end
endmodule

// File: doc/sif_div_fp_iter.md
# sif_div_fp_iter

- Parametrised, self-contained IEEE-style floating-point divider (default FP16) with valid/ready streams on both operands and the result.
- Joins the A (dividend) and B (divisor) streams, classifies special operands, and runs a radix-2 restoring mantissa division over MAN_W+3 cycles.
- Applies round-to-nearest-even and returns the quotient with exception flags.
- Sits in the NPU datapath wherever a divide is needed (normalisation, softmax scaling); one operation in flight.

## Interface
- EXP_W, 5, exponent width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa width; word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- A_vld / A_dat / A_rdy  in/in/out  1/W/1  dividend stream.
- B_vld / B_dat / B_rdy  in/in/out  1/W/1  divisor stream.
- P_vld / P_dat / P_rdy  out/out/in  1/W/1  quotient stream.
- P_flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}; valid with P_vld.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, DIV, NORM_RND, OUT.
- IDLE: A_rdy = B_rdy = A_vld & B_vld. Both operands are consumed on the same edge; a lone valid is never accepted.
- On accept, the operands are classified. Subnormal inputs are treated as ±0 (flush-to-zero).
- The result sign is sA^sB, except for NaN results.
- Special-case priority:
  - Either operand NaN, 0/0 or inf/inf: canonical qNaN (sign 0, exponent all ones, mantissa MSB only; 0x7E00 for FP16). Sets invalid, except for a NaN input.
  - Finite nonzero / 0: ±inf, sets div_by_zero.
  - inf / finite: ±inf.
  - 0 / nonzero, or finite / inf: ±0.
- Special cases jump IDLE -> OUT with the result preloaded.
- Normal case: Ma and Mb carry the hidden 1 (MAN_W+1 bits). Exponent e = Ea - Eb + BIAS, held signed in EXP_W+2 bits. Next state DIV.
- DIV: one quotient bit per cycle, MAN_W+3 cycles.
  - Q = floor(Ma·2^(MAN_W+2)/Mb); R = remainder.
  - An iteration counter of width clog2(MAN_W+4) counts down to 0.
- NORM_RND:
  - If Q[MAN_W+2] = 1: mant = Q[MAN_W+2:2], guard = Q[1], sticky = Q[0] | (R≠0).
  - Else: e -= 1, mant = Q[MAN_W+1:1], guard = Q[0], sticky = (R≠0).
  - RNE: increment mant when guard & (sticky | mant[0]). A carry out renormalises mant to 1.0 and sets e += 1. inexact = guard | sticky.
  - If e ≥ 2^EXP_W-1: ±inf, sets overflow and inexact.
  - If e ≤ 0: ±0, sets underflow and inexact (no subnormal output).
- OUT: P_vld = 1. P_dat and P_flags are stable until P_rdy; on P_vld & P_rdy go to IDLE.

## Timing
- Reset values: state IDLE; P_vld, busy, A_rdy, B_rdy = 0; P_dat = 0; P_flags = 0.
- All internal registers are cleared on reset. Reset mid-operation aborts the operation, and no result is emitted.
- Latency is counted from the accept edge to the first cycle with P_vld high:
  - Normal operands: MAN_W+5 cycles (15 for FP16).
  - Special cases: 1 cycle.
- No new accept occurs before the OUT handshake completes. With P_rdy held high, back-to-back normal operations accept every MAN_W+6 cycles.
- Inputs arriving while busy wait; A_rdy and B_rdy stay 0.
- P_rdy high on the first OUT cycle returns the block to IDLE on that edge. A new accept is possible on the following cycle.

## Structure
- Package sif_fp_pkg holds:
  - The state enum.
  - Flag bit indices (FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0).
  - A canonical-NaN function parametrised by EXP_W and MAN_W.
- Sub-module sif_fp_classify (combinational, instantiated twice) returns {is_zero, is_inf, is_nan, sign, exp, sig_with_hidden} for one operand, applying FTZ.

## Test plan
- 0x3C00/0x4000 -> P_dat 0x3800, flags 0, P_vld exactly 15 cycles after accept. 0x4600/0x4200 -> 0x4000.
- 0x3C00/0x4200 (1/3) -> 0x3555, inexact only. 0x4000/0x4200 -> 0x3955, inexact.
- Specials, 1-cycle latency each:
  - 0x3C00/0x0000 -> 0x7C00, DZ.
  - 0x0000/0x0000 -> 0x7E00, NV.
  - 0x7C00/0x7C00 -> 0x7E00, NV.
  - 0xBC00/0x7C00 -> 0x8000.
- 0x7BFF/0x3800 -> 0x7C00, OF|NX. 0x0400/0x4000 -> 0x0000, UF|NX. Subnormal 0x0001/0x3C00 -> 0x0000.
- Backpressure: hold P_rdy low 10 cycles. P_dat/P_flags stay stable, and A_rdy/B_rdy stay 0 with new operands pending. Release -> the next operation is accepted on the following cycle.
- Reset and join:
  - Deassert rst_n during DIV: P_vld never asserts, and the next operation gives a correct result.
  - A_vld alone for 5 cycles -> A_rdy stays 0.
